// File: rtl/resp_fanin_tree.sv
// resp_fanin_tree: merges N_CH upstream response channels into a single
// registered response stream. Arbitration is fixed priority: the lowest
// valid index wins. There is no backpressure, so any losing response in a
// collision cycle is dropped. A collision raises a one-cycle pulse and a
// sticky error flag.
// Optional build macro RESP_FANIN_COLL_CNT_EN adds a saturating collision
// counter on port coll_cnt_o.
module resp_fanin_tree #(
  parameter  int N_CH       = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int CNT_WIDTH  = 8,
  localparam int ID_WIDTH   = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            data_r_valid_i,
  input  logic [N_CH*DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                       err_clear_i,
  output logic                       data_r_valid_o,
  output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
  output logic [ID_WIDTH-1:0]        data_r_id_o,
  output logic                       coll_o,
  output logic                       coll_err_o
`ifdef RESP_FANIN_COLL_CNT_EN
  ,output logic [CNT_WIDTH-1:0]      coll_cnt_o
`endif
);

  // Reject parameter values the block cannot support.
  if (N_CH < 2 || N_CH > 64) begin : g_bad_nch
    $error("resp_fanin_tree: N_CH must be in 2..64");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("resp_fanin_tree: CNT_WIDTH must be >= 1");
  end

  logic                  any_valid;
  logic                  collision;
  logic [ID_WIDTH-1:0]   win_id;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  coll_q;
  logic                  err_q, err_d;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign any_valid = |data_r_valid_i;
  assign collision = |(data_r_valid_i & (data_r_valid_i - N_CH'(1)));

  // Fixed-priority pick: scan high to low so the lowest valid index wins.
  always_comb begin
    win_id   = '0;
    win_data = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      if (data_r_valid_i[k]) begin
        win_id   = ID_WIDTH'(k);
        win_data = data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state: data/id hold while idle. For the sticky flag, set beats clear.
  always_comb begin
    rdata_d = rdata_q;
    id_d    = id_q;
    if (any_valid) begin
      rdata_d = win_data;
      id_d    = win_id;
    end
    err_d = err_q;
    if (collision)        err_d = 1'b1;
    else if (err_clear_i) err_d = 1'b0;
  end

  // Single register stage for every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      id_q    <= '0;
      coll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= any_valid;
      rdata_q <= rdata_d;
      id_q    <= id_d;
      coll_q  <= collision;
      err_q   <= err_d;
    end
  end

  assign data_r_valid_o = valid_q;
  assign data_r_rdata_o = rdata_q;
  assign data_r_id_o    = id_q;
  assign coll_o         = coll_q;
  assign coll_err_o     = err_q;

`ifdef RESP_FANIN_COLL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating count of collision cycles. A clear restarts the count, and a
  // collision arriving in the same cycle as the clear is counted as 1.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clear_i)                    cnt_d = collision ? CNT_WIDTH'(1) : '0;
    else if (collision && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign coll_cnt_o = cnt_q;
`endif

endmodule
